input_event_target: RTL
=======================

// Module: input_event_target
// PURPOSE
//  Wishbone classic target; sits directly downstream of the debounced button/switch controller.
//  Accepts 8-bit input-state snapshot writes and derives per-bit rise/fall masks.
//  Queues non-empty edge records in a small FIFO and raises an interrupt.
//  Software reads and pops the records over the same bus.
// PARAMETERS
//  DATA_WIDTH   32  bus data width; must be >= 2*INPUT_WIDTH+2
//  ADDR_WIDTH   2   word address width; 4 registers
//  INPUT_WIDTH  8   snapshot width: {switches[3:0], buttons[3:0]}
//  FIFO_DEPTH   8   event queue entries; power of two, >= 2
// PORTS
//  clk_i   in   1           single clock
//  rst_ni  in   1           reset, asynchronous, active-low
//  cyc_i   in   1           wishbone cycle
//  stb_i   in   1           wishbone strobe
//  we_i    in   1           1 = write
//  adr_i   in   ADDR_WIDTH  word address
//  dat_i   in   DATA_WIDTH  write data
//  dat_o   out  DATA_WIDTH  read data, valid while ack_o=1
//  ack_o   out  1           transfer acknowledge
//  irq_o   out  1           level interrupt: event pending and enabled
// BEHAVIOUR
//  Reset (rst_ni=0, async): ack_o=0, dat_o=0, irq_o=0, state=0, FIFO empty, overflow=0, irq_en=0.
//   Reset asserted mid-transfer aborts the transfer; nothing commits.
//  Handshake:
//   ack_o <= cyc_i & stb_i & ~ack_o, so ack comes 1 cycle after request and lasts 1 cycle.
//   Back-to-back requests are acked every other cycle.
//   Side effects (write, pop, clear) commit on the clock edge where ack_o rises.
//   dat_o is registered with ack_o; it is 0 when ack_o=0.
//  Register map:
//   0 STATE   W: new = dat_i[INPUT_WIDTH-1:0].
//               rise = new & ~state; fall = ~new & state.
//               state <= new; push {fall,rise} if (rise|fall) != 0.
//             R: current state, zero-extended.
//   1 EVENT   R: {valid, overflow, 14'b0, fall[7:0], rise[7:0]} of the FIFO head.
//               Pops if non-empty.
//               Empty FIFO: returns 0, no pop, no pointer change.
//             W: ignored, still acked.
//   2 STATUS  R: [7:0] occupancy, [8] empty, [9] full, [10] overflow.
//             W: dat_i[10]=1 clears overflow; other bits ignored.
//   3 IRQ_EN  R/W: bit0 = irq enable; other bits read 0.
//  Full FIFO on a push: the new record is dropped, the FIFO is unchanged, overflow (sticky) is set.
//  A STATE write with no edges updates state but pushes nothing.
//  Push and pop can never coincide; there is only one bus port.
//  Pointers wrap modulo FIFO_DEPTH. Occupancy ranges 0..FIFO_DEPTH; full when occupancy==FIFO_DEPTH.
//  irq_o is registered: irq_o <= irq_en & ~empty, so it follows FIFO/enable changes by 1 cycle.
//  Out-of-range data bits: writes ignore them, reads return them as 0.
// STRUCTURE
//  Package input_event_pkg holds:
//   - reg_addr_e enum {ADDR_STATE, ADDR_EVENT, ADDR_STATUS, ADDR_IRQ_EN}
//   - event_t packed struct {fall, rise}
//   - STATUS bit-position localparams
//  Sub-module event_fifo: synchronous FIFO with push/pop/full/empty/count.
//   Parameters: depth and element type.
//   Reused for other peripheral queues.
//  Top level holds the bus FSM, edge detect, registers and irq.
// TESTING
//  1. Reset, write STATE=0x05 -> ack_o 1 cycle after stb; EVENT read=0x8000_0005; STATUS then=0x100.
//  2. Write STATE 0x05 then 0x06 -> EVENT reads 0x8000_0005, then 0x8000_0102; irq_en=1 -> irq_o falls after pop.
//  3. Write STATE=0x03 twice -> second write pushes nothing; occupancy stays 1.
//  4. 9 edge-producing writes, depth 8 -> STATUS=0x608; 9th record absent; clear write -> STATUS=0x208.
//  5. EVENT read when empty -> dat_o=0x0000_0000, occupancy stays 0, no pointer corruption.
//  6. Drop rst_ni during a request with 4 events queued -> ack_o/irq_o 0 immediately; STATUS=0x100 after.

Source files
------------

// File: rtl/input_event_pkg.sv
// Shared types for the input-event Wishbone target: register map, bus FSM
// states, the edge record and the STATUS bit layout.
package input_event_pkg;

  localparam int INPUT_W = 8;

  typedef enum logic [1:0] {
    ADDR_STATE  = 2'd0,
    ADDR_EVENT  = 2'd1,
    ADDR_STATUS = 2'd2,
    ADDR_IRQ_EN = 2'd3
  } reg_addr_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  typedef struct packed {
    logic [INPUT_W-1:0] fall;
    logic [INPUT_W-1:0] rise;
  } event_t;

  localparam int STATUS_COUNT_W   = 8;
  localparam int STATUS_EMPTY_BIT = 8;
  localparam int STATUS_FULL_BIT  = 9;
  localparam int STATUS_OVF_BIT   = 10;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with occupancy count; element type and depth are parameters
// so other peripheral queues can reuse it. Pushes when full are ignored.
module event_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == DEPTH[PW:0]);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_event_target.sv
// Wishbone classic target taking debounced input snapshots, queueing rise/fall
// edge records for software and raising a level interrupt while any are pending.
module input_event_target
  import input_event_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 2,
  parameter int INPUT_WIDTH = INPUT_W,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a request (cyc_i & stb_i) seen in BUS_IDLE is acked on the next
  // edge for exactly one cycle; all side effects commit on that same edge, and
  // dat_o carries read data only while ack_o is high.
  bus_state_e              bus_state;
  reg_addr_e               addr;
  logic [INPUT_WIDTH-1:0]  state;
  logic                    overflow;
  logic                    irq_en;

  logic                    req;
  logic                    wr;
  logic                    rd;
  logic [INPUT_WIDTH-1:0]  new_state;
  logic [INPUT_WIDTH-1:0]  rise;
  logic [INPUT_WIDTH-1:0]  fall;
  logic                    has_edge;
  logic                    push_req;
  logic                    push;
  logic                    pop;
  event_t                  push_rec;
  event_t                  head;
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           count;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    unused_dat;

  assign addr      = reg_addr_e'(adr_i);
  assign req       = cyc_i & stb_i & (bus_state == BUS_IDLE);
  assign wr        = req & we_i;
  assign rd        = req & ~we_i;

  assign new_state = dat_i[INPUT_WIDTH-1:0];
  assign rise      = new_state & ~state;
  assign fall      = ~new_state & state;
  assign has_edge  = |(rise | fall);
  assign push_rec  = '{fall: fall, rise: rise};

  assign push_req  = wr & (addr == ADDR_STATE) & has_edge;
  assign push      = push_req & ~full;
  assign pop       = rd & (addr == ADDR_EVENT) & ~empty;

  assign unused_dat = ^dat_i;

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (event_t)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_STATE: rd_data[INPUT_WIDTH-1:0] = state;
      ADDR_EVENT: begin
        if (!empty) begin
          rd_data[DATA_WIDTH-1]          = 1'b1;
          rd_data[DATA_WIDTH-2]          = overflow;
          rd_data[2*INPUT_WIDTH-1:0]     = head;
        end
      end
      ADDR_STATUS: begin
        rd_data[CW-1:0]             = count;
        rd_data[STATUS_EMPTY_BIT]   = empty;
        rd_data[STATUS_FULL_BIT]    = full;
        rd_data[STATUS_OVF_BIT]     = overflow;
      end
      ADDR_IRQ_EN: rd_data[0] = irq_en;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_state <= BUS_IDLE;
      ack_o     <= 1'b0;
      dat_o     <= '0;
      irq_o     <= 1'b0;
      state     <= '0;
      overflow  <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      irq_o <= irq_en & ~empty;

      case (bus_state)
        BUS_IDLE: begin
          if (req) begin
            bus_state <= BUS_ACK;
            ack_o     <= 1'b1;
            dat_o     <= we_i ? '0 : rd_data;
          end else begin
            ack_o <= 1'b0;
            dat_o <= '0;
          end
        end
        default: begin
          bus_state <= BUS_IDLE;
          ack_o     <= 1'b0;
          dat_o     <= '0;
        end
      endcase

      if (wr) begin
        case (addr)
          ADDR_STATE:  state <= new_state;
          ADDR_STATUS: if (dat_i[STATUS_OVF_BIT]) overflow <= 1'b0;
          ADDR_IRQ_EN: irq_en <= dat_i[0];
          default:     ;
        endcase
      end

      // A record arriving at a full queue is dropped; the loss stays visible.
      if (push_req && full) overflow <= 1'b1;
    end
  end

endmodule
